// File: rtl/washer_pkg.sv
// Shared definitions for the washer sequencer.
//   - Mode codes sent to the motor function stage.
//   - Course codes and the course -> first/last phase mapping.
//   - Phase indices (2 bits) and the sequencer state enum.
package washer_pkg;

  // Motor function stage mode codes.
  localparam logic [2:0] MODE_STOP  = 3'd0;
  localparam logic [2:0] MODE_WASH  = 3'd1;
  localparam logic [2:0] MODE_RINSE = 3'd2;
  localparam logic [2:0] MODE_SPIN  = 3'd3;

  // Course codes.
  localparam logic [1:0] COURSE_FULL       = 2'd0;  // wash -> rinse -> spin
  localparam logic [1:0] COURSE_WASH       = 2'd1;  // wash only
  localparam logic [1:0] COURSE_RINSE_SPIN = 2'd2;  // rinse -> spin
  localparam logic [1:0] COURSE_SPIN       = 2'd3;  // spin only

  // Phase indices; also the bit position in the phase LED vector.
  localparam logic [1:0] PHASE_WASH  = 2'd0;
  localparam logic [1:0] PHASE_RINSE = 2'd1;
  localparam logic [1:0] PHASE_SPIN  = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StGap,
    StDone
  } state_e;

  typedef struct packed {
    logic [1:0] first;
    logic [1:0] last;
  } phase_range_t;

  function automatic phase_range_t course_phases(input logic [1:0] course);
    phase_range_t r;
    r.first = PHASE_SPIN;
    r.last  = PHASE_SPIN;
    case (course)
      COURSE_FULL: begin
        r.first = PHASE_WASH;
        r.last  = PHASE_SPIN;
      end
      COURSE_WASH: begin
        r.first = PHASE_WASH;
        r.last  = PHASE_WASH;
      end
      COURSE_RINSE_SPIN: begin
        r.first = PHASE_RINSE;
        r.last  = PHASE_SPIN;
      end
      COURSE_SPIN: begin
        r.first = PHASE_SPIN;
        r.last  = PHASE_SPIN;
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] phase_to_mode(input logic [1:0] phase);
    logic [2:0] m;
    m = MODE_STOP;
    case (phase)
      PHASE_WASH:  m = MODE_WASH;
      PHASE_RINSE: m = MODE_RINSE;
      PHASE_SPIN:  m = MODE_SPIN;
      default:     m = MODE_STOP;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] phase_to_led(input logic [1:0] phase);
    logic [2:0] led;
    led = 3'b000;
    case (phase)
      PHASE_WASH:  led = 3'b001;
      PHASE_RINSE: led = 3'b010;
      PHASE_SPIN:  led = 3'b100;
      default:     led = 3'b000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-flop synchronizer followed by a registered rising-edge detector.
// Ports:
//   clk_i   - system clock
//   reset_i - synchronous active-high reset
//   btn_i   - raw asynchronous button level
//   pulse_o - one-cycle pulse, registered, 3 edges after btn_i first rises
module btn_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/washer_sequencer.sv
// Washer course sequencer driving the motor function stage.
// Ports:
//   i_clk, i_reset              - clock, synchronous active-high reset
//   i_btn_start/course/stop     - raw asynchronous buttons
//   i_fin                       - phase-finished level from the motor stage (asynchronous)
//   o_mode                      - 0 stop, 1 wash, 2 rinse, 3 spin
//   o_course                    - selected course
//   o_phase_led                 - one-hot active phase while running
//   o_busy, o_done, o_buzz      - status and buzzer enable
module washer_sequencer
  import washer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 100_000_000,
  parameter int unsigned BUZZ_CYCLES = 300_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_start,
  input  logic       i_btn_course,
  input  logic       i_btn_stop,
  input  logic       i_fin,
  output logic [2:0] o_mode,
  output logic [1:0] o_course,
  output logic [2:0] o_phase_led,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_buzz
);

  localparam int unsigned CntMax = (GAP_CYCLES > BUZZ_CYCLES) ? GAP_CYCLES : BUZZ_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] BuzzLast = CntW'(BUZZ_CYCLES - 1);

  logic start_p;
  logic course_p;
  logic stop_p;
  logic fin_meta_q;
  logic fin_s;

  btn_edge u_btn_start (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .btn_i   (i_btn_start),
    .pulse_o (start_p)
  );

  btn_edge u_btn_course (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .btn_i   (i_btn_course),
    .pulse_o (course_p)
  );

  btn_edge u_btn_stop (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .btn_i   (i_btn_stop),
    .pulse_o (stop_p)
  );

  // fin is a level, so only synchronize it; the armed flag handles edge qualification.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fin_meta_q <= 1'b0;
      fin_s      <= 1'b0;
    end else begin
      fin_meta_q <= i_fin;
      fin_s      <= fin_meta_q;
    end
  end

  state_e          state_q;
  logic [1:0]      phase_q;
  logic [1:0]      last_q;   // last phase of the course, latched at start
  logic            armed_q;  // fin_s has been seen low in this phase
  logic [CntW-1:0] cnt_q;
  phase_range_t    range;

  assign range = course_phases(o_course);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      last_q      <= '0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      o_mode      <= MODE_STOP;
      o_course    <= '0;
      o_phase_led <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_buzz      <= 1'b0;
    end else if (stop_p && (state_q != StIdle)) begin
      // Stop outranks fin and counter expiry; course selection is kept.
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      o_mode      <= MODE_STOP;
      o_phase_led <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_buzz      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_p) begin
            state_q     <= StRun;
            phase_q     <= range.first;
            last_q      <= range.last;
            armed_q     <= 1'b0;
            o_mode      <= phase_to_mode(range.first);
            o_phase_led <= phase_to_led(range.first);
            o_busy      <= 1'b1;
          end else if (course_p) begin
            o_course <= o_course + 2'd1;
          end
        end
        StRun: begin
          if (armed_q && fin_s) begin
            cnt_q       <= '0;
            o_mode      <= MODE_STOP;
            o_phase_led <= '0;
            if (phase_q == last_q) begin
              state_q <= StDone;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              o_buzz  <= 1'b1;
            end else begin
              state_q <= StGap;
              phase_q <= phase_q + 2'd1;
            end
          end else if (!fin_s) begin
            armed_q <= 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_q     <= StRun;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            o_mode      <= phase_to_mode(phase_q);
            o_phase_led <= phase_to_led(phase_q);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (cnt_q == BuzzLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            o_done  <= 1'b0;
            o_buzz  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
